win_scan_controller: RTL and testbench
======================================

WIN_SCAN_CONTROLLER -- requirements
Module: win_scan_controller

Interface
REQ-001 Parameters: none; board fixed at 6 rows x 7 columns, win length 4, row 0 = bottom, col 0 = left.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clock and reset.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a full-board win scan; sampled only in IDLE.
REQ-006 board_rd_en  output  1  board read strobe; high on every scan address cycle.
REQ-007 board_row  output  3  read row address, 0..5.
REQ-008 board_col  output  3  read column address, 0..6.
REQ-009 board_piece  input  2  board read data, valid the cycle after the address (00 empty, 01 red, 10 yellow, 11 treated as empty).
REQ-010 rec_in  output  2  piece fed to the sequence recognizer.
REQ-011 rec_reset  output  1  active-low synchronous clear for the recognizer.
REQ-012 rec_out  input  2  recognizer result (00 none, 01 red four, 10 yellow four).
REQ-013 busy  output  1  scan in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 winner  output  2  scan result, held until next accepted start.

Function
REQ-016 States SHALL be IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start, SCAN->DRAIN after the last address cycle, DRAIN->DONE after two cycles, DONE->IDLE after one cycle.
REQ-017 The cycle in which start is sampled high in IDLE is cycle 0; the first address SHALL be issued in cycle 1, and winner SHALL clear to 00 in cycle 1.
REQ-018 Line order SHALL be: rows 0..5 (cols 0..6 each), then columns 0..6 (rows 0..5 each), then diagonals when enabled (REQ-030).
REQ-019 Each line of length L SHALL occupy L consecutive address cycles followed by one gap cycle with board_rd_en low.
REQ-020 rec_in SHALL equal board_piece in the cycle after a read, and 00 in the cycle after a gap, so each line starts from a cleared recognizer.
REQ-021 rec_reset SHALL be low in IDLE and DONE and high in SCAN and DRAIN.
REQ-022 rec_out SHALL be checked every cycle from cycle 2 through the final DRAIN cycle.
REQ-023 On the first nonzero rec_out in cycle k: latch winner = rec_out, drop board_rd_en, and assert done in cycle k+1.
REQ-024 With no win, done SHALL assert in cycle 99 with diagonals disabled, or cycle 171 with diagonals enabled.
REQ-025 busy SHALL be high from cycle 1 up to, but not including, the done cycle.
REQ-026 start SHALL be ignored while not in IDLE.
REQ-027 Board contents SHALL be assumed stable during a scan; no other read interface handshake exists.

Reset
REQ-028 reset low SHALL immediately force IDLE, board_rd_en=0, board_row=0, board_col=0, rec_in=00, rec_reset=0, busy=0, done=0, winner=00, including mid-scan.
REQ-029 After reset deassertion, the first start SHALL behave exactly as REQ-017.

Configuration
REQ-030 Macro WIN_SCAN_DIAG_EN defined: after the columns, the block SHALL scan rising diagonals (row+1, col+1) starting at (2,0),(1,0),(0,0),(0,1),(0,2),(0,3), then falling diagonals (row-1, col+1) starting at (3,0),(4,0),(5,0),(5,1),(5,2),(5,3).
REQ-031 Macro undefined: no diagonal logic is compiled, and the scan ends after column 6.

Verification
REQ-032 Empty board, start -> done in cycle 99 (171 with WIN_SCAN_DIAG_EN), winner=00, busy high cycles 1..98 (1..170).
REQ-033 Red at (0,0)-(0,3) -> rec_out=01 in cycle 6, done in cycle 7, winner=01, board_rd_en low from cycle 7.
REQ-034 Yellow at col 6 rows 2-5 -> done in cycle 99, winner=10.
REQ-035 Red at (0,4),(0,5),(0,6),(1,0), macro undefined -> gap breaks run, done in cycle 99, winner=00.
REQ-036 Red at (0,0),(1,1),(2,2),(3,3) -> with macro: done in cycle 115, winner=01; without macro: done in cycle 99, winner=00.
REQ-037 Start pulsed in cycle 20 and reset low in cycle 40 -> start in cycle 20 ignored; all outputs at reset values in cycle 40; a new start scans normally.

Source files
------------

// File: rtl/win_scan_controller.sv
// Win-line scanner for a 6x7 board that feeds every row and column through an external four-in-a-row recognizer.
// Optional macro WIN_SCAN_DIAG_EN adds the rising and falling diagonals after the columns.
module win_scan_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       board_rd_en,
    output logic [2:0] board_row,
    output logic [2:0] board_col,
    input  logic [1:0] board_piece,
    output logic [1:0] rec_in,
    output logic       rec_reset,
    input  logic [1:0] rec_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {PH_ROWS = 2'd0, PH_COLS = 2'd1, PH_RISE = 2'd2, PH_FALL = 2'd3} phase_t;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d, next_phase;
    logic [2:0] row_q, row_d, col_q, col_d;
    logic       rd_en_q, rd_en_d, rd_prev_q, rd_prev_d;
    logic       chk_q, chk_d, drain_q, drain_d;
    logic       busy_q, busy_d, done_q, done_d, rec_reset_q, rec_reset_d;
    logic [1:0] winner_q, winner_d;
    logic       line_end, scan_end;
    logic [2:0] step_row, step_col, start_row, start_col;
`ifdef WIN_SCAN_DIAG_EN
    logic [2:0] line_q, line_d, line_inc, next_line;
`endif

    // Line geometry: the next address inside the current line, and where the following line begins.
    always_comb begin
        step_row   = row_q;
        step_col   = col_q;
        start_row  = 3'd0;
        start_col  = 3'd0;
        line_end   = 1'b0;
        scan_end   = 1'b0;
        next_phase = phase_q;
`ifdef WIN_SCAN_DIAG_EN
        line_inc   = line_q + 3'd1;
        next_line  = line_inc;
`endif
        case (phase_q)
            PH_ROWS: begin
                step_col = col_q + 3'd1;
                line_end = (col_q == 3'd6);
                if (row_q == 3'd5) next_phase = PH_COLS;
                else               start_row  = row_q + 3'd1;
            end
            PH_COLS: begin
                step_row = row_q + 3'd1;
                line_end = (row_q == 3'd5);
                if (col_q == 3'd6) begin
`ifdef WIN_SCAN_DIAG_EN
                    next_phase = PH_RISE;
                    start_row  = 3'd2;
                    next_line  = 3'd0;
`else
                    scan_end   = 1'b1;
`endif
                end else begin
                    start_col = col_q + 3'd1;
                end
            end
`ifdef WIN_SCAN_DIAG_EN
            PH_RISE: begin
                step_row = row_q + 3'd1;
                step_col = col_q + 3'd1;
                line_end = (row_q == 3'd5) || (col_q == 3'd6);
                if (line_q == 3'd5) begin
                    next_phase = PH_FALL;
                    start_row  = 3'd3;
                    next_line  = 3'd0;
                end else if (line_inc <= 3'd2) begin
                    start_row = 3'd2 - line_inc;
                end else begin
                    start_col = line_inc - 3'd2;
                end
            end
            PH_FALL: begin
                step_row = row_q - 3'd1;
                step_col = col_q + 3'd1;
                line_end = (row_q == 3'd0) || (col_q == 3'd6);
                if (line_q == 3'd5) begin
                    scan_end = 1'b1;
                end else if (line_inc <= 3'd2) begin
                    start_row = 3'd3 + line_inc;
                end else begin
                    start_row = 3'd5;
                    start_col = line_inc - 3'd2;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_en_d     = rd_en_q;
        rd_prev_d   = rd_en_q;
        chk_d       = chk_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rec_reset_d = rec_reset_q;
        winner_d    = winner_q;
`ifdef WIN_SCAN_DIAG_EN
        line_d      = line_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    phase_d     = PH_ROWS;
                    row_d       = 3'd0;
                    col_d       = 3'd0;
                    rd_en_d     = 1'b1;
                    chk_d       = 1'b0;
                    busy_d      = 1'b1;
                    rec_reset_d = 1'b1;
                    winner_d    = 2'b00;
`ifdef WIN_SCAN_DIAG_EN
                    line_d      = 3'd0;
`endif
                end
            end
            SCAN: begin
                chk_d = 1'b1;
                if (chk_q && (rec_out != 2'b00)) begin
                    state_d     = DONE;
                    winner_d    = rec_out;
                    rd_en_d     = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    rec_reset_d = 1'b0;
                end else if (!rd_en_q) begin
                    rd_en_d = 1'b1;
                end else if (!line_end) begin
                    row_d = step_row;
                    col_d = step_col;
                end else begin
                    // The gap after the final line doubles as the first drain cycle.
                    rd_en_d = 1'b0;
                    if (scan_end) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        row_d   = start_row;
                        col_d   = start_col;
                        phase_d = next_phase;
`ifdef WIN_SCAN_DIAG_EN
                        line_d  = next_line;
`endif
                    end
                end
            end
            DRAIN: begin
                if ((rec_out != 2'b00) || drain_q) begin
                    state_d     = DONE;
                    winner_d    = rec_out;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    rec_reset_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= PH_ROWS;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            rd_en_q     <= 1'b0;
            rd_prev_q   <= 1'b0;
            chk_q       <= 1'b0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rec_reset_q <= 1'b0;
            winner_q    <= 2'b00;
`ifdef WIN_SCAN_DIAG_EN
            line_q      <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_en_q     <= rd_en_d;
            rd_prev_q   <= rd_prev_d;
            chk_q       <= chk_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rec_reset_q <= rec_reset_d;
            winner_q    <= winner_d;
`ifdef WIN_SCAN_DIAG_EN
            line_q      <= line_d;
`endif
        end
    end

    // Read data arrives one cycle after its address; a gap feeds 00 so the recognizer's run breaks.
    assign rec_in      = (rd_prev_q && rec_reset_q && (board_piece != 2'b11)) ? board_piece : 2'b00;
    assign board_rd_en = rd_en_q;
    assign board_row   = row_q;
    assign board_col   = col_q;
    assign rec_reset   = rec_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign winner      = winner_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_win_scan_controller.sv
// Directed bench for win_scan_controller with a board memory and four-in-a-row recognizer model.
module tb_win_scan_controller;

    localparam int MAX_CYC = 250;
`ifdef WIN_SCAN_DIAG_EN
    localparam int       LAST_CYC  = 171;
    localparam int       DIAG_DONE = 115;
    localparam bit [1:0] DIAG_WIN  = 2'b01;
    localparam bit [1:0] ST_97     = 2'd1;
`else
    localparam int       LAST_CYC  = 99;
    localparam int       DIAG_DONE = 99;
    localparam bit [1:0] DIAG_WIN  = 2'b00;
    localparam bit [1:0] ST_97     = 2'd2;
`endif

    logic       clock;
    logic       reset;
    logic       start;
    logic       board_rd_en;
    logic [2:0] board_row;
    logic [2:0] board_col;
    logic [1:0] board_piece;
    logic [1:0] rec_in;
    logic       rec_reset;
    logic [1:0] rec_out;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic [1:0] state_dbg;

    int checks = 0;
    int failures = 0;

    logic [1:0] board [0:5][0:6];
    logic [1:0] run_col;
    int         run_len;

    int         obs_done_cyc, obs_rec_cyc, obs_busy_bad;
    logic [1:0] obs_winner;
    logic       obs_busy_at_done, obs_done_after;
    logic [1:0] obs_state_after;
    logic       cap_rd [0:MAX_CYC];
    logic [2:0] cap_row [0:MAX_CYC];
    logic [2:0] cap_col [0:MAX_CYC];
    logic [1:0] cap_rec_in [0:MAX_CYC];
    logic       cap_rec_reset [0:MAX_CYC];
    logic [1:0] cap_state [0:MAX_CYC];
    logic [1:0] cap_winner [0:MAX_CYC];

    win_scan_controller dut (
        .clock(clock), .reset(reset), .start(start),
        .board_rd_en(board_rd_en), .board_row(board_row), .board_col(board_col),
        .board_piece(board_piece), .rec_in(rec_in), .rec_reset(rec_reset),
        .rec_out(rec_out), .busy(busy), .done(done), .winner(winner),
        .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Board memory: data valid the cycle after the address.
    always @(posedge clock) begin
        if (board_rd_en && board_row <= 3'd5 && board_col <= 3'd6)
            board_piece <= board[board_row][board_col];
        else
            board_piece <= 2'b00;
    end

    // Recognizer: reports a colour one cycle after its fourth consecutive piece.
    always @(posedge clock) begin
        if (!rec_reset) begin
            run_len <= 0;
            run_col <= 2'b00;
            rec_out <= 2'b00;
        end else if (rec_in == 2'b01 || rec_in == 2'b10) begin
            if (rec_in == run_col) begin
                run_len <= run_len + 1;
                rec_out <= (run_len + 1 >= 4) ? rec_in : 2'b00;
            end else begin
                run_len <= 1;
                run_col <= rec_in;
                rec_out <= 2'b00;
            end
        end else begin
            run_len <= 0;
            run_col <= 2'b00;
            rec_out <= 2'b00;
        end
    end

    task automatic clear_board();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                board[r][c] = 2'b00;
    endtask

    // Pulses start for cycle 0 and records outputs every cycle until done or the budget runs out.
    task automatic run_scan();
        obs_done_cyc = -1;
        obs_rec_cyc = -1;
        obs_busy_bad = 0;
        obs_winner = 2'bxx;
        obs_busy_at_done = 1'bx;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= MAX_CYC && obs_done_cyc < 0; c++) begin
            @(negedge clock);
            cap_rd[c] = board_rd_en;
            cap_row[c] = board_row;
            cap_col[c] = board_col;
            cap_rec_in[c] = rec_in;
            cap_rec_reset[c] = rec_reset;
            cap_state[c] = state_dbg;
            cap_winner[c] = winner;
            if (obs_rec_cyc < 0 && rec_out != 2'b00) obs_rec_cyc = c;
            if (done === 1'b1) begin
                obs_done_cyc = c;
                obs_winner = winner;
                obs_busy_at_done = busy;
            end else if (busy !== 1'b1) begin
                obs_busy_bad++;
            end
        end
        @(negedge clock);
        obs_done_after = done;
        obs_state_after = state_dbg;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (board_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", board_rd_en); end
        checks++; if (board_row !== 3'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", board_row); end
        checks++; if (board_col !== 3'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", board_col); end
        checks++; if (rec_in !== 2'b00) begin failures++; $display("FAIL reset_rec_in got=%b exp=00", rec_in); end
        checks++; if (rec_reset !== 1'b0) begin failures++; $display("FAIL reset_rec_reset got=%0b exp=0", rec_reset); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (winner !== 2'b00) begin failures++; $display("FAIL reset_winner got=%b exp=00", winner); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_empty_board();
        int tc [11] = '{1, 7, 8, 9, 48, 49, 54, 55, 56, 96, 97};
        bit trd [11] = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0};
        int trow [11] = '{0, 0, 0, 1, 0, 0, 5, 0, 0, 5, 0};
        int tcol [11] = '{0, 6, 0, 0, 0, 0, 0, 0, 1, 6, 0};
        clear_board();
        run_scan();
        checks++; if (obs_done_cyc != LAST_CYC) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=%0d", obs_done_cyc, LAST_CYC); end
        checks++; if (obs_winner !== 2'b00) begin failures++; $display("FAIL empty_winner got=%b exp=00", obs_winner); end
        checks++; if (obs_busy_bad != 0) begin failures++; $display("FAIL empty_busy_low_cycles got=%0d exp=0", obs_busy_bad); end
        checks++; if (obs_busy_at_done !== 1'b0) begin failures++; $display("FAIL empty_busy_at_done got=%0b exp=0", obs_busy_at_done); end
        checks++; if (obs_done_after !== 1'b0) begin failures++; $display("FAIL empty_done_pulse got=%0b exp=0", obs_done_after); end
        checks++; if (obs_state_after !== 2'd0) begin failures++; $display("FAIL empty_state_after got=%0d exp=0", obs_state_after); end
        checks++; if (cap_state[97] !== ST_97) begin failures++; $display("FAIL empty_state_c97 got=%0d exp=%0d", cap_state[97], ST_97); end
        checks++; if (cap_rec_reset[1] !== 1'b1) begin failures++; $display("FAIL empty_rec_reset_c1 got=%0b exp=1", cap_rec_reset[1]); end
        checks++; if (cap_rec_reset[LAST_CYC-1] !== 1'b1) begin failures++; $display("FAIL empty_rec_reset_last got=%0b exp=1", cap_rec_reset[LAST_CYC-1]); end
        checks++; if (cap_rec_reset[LAST_CYC] !== 1'b0) begin failures++; $display("FAIL empty_rec_reset_done got=%0b exp=0", cap_rec_reset[LAST_CYC]); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (cap_rd[tc[i]] !== trd[i] ||
                (trd[i] && (cap_row[tc[i]] != 3'(trow[i]) || cap_col[tc[i]] != 3'(tcol[i])))) begin
                failures++;
                $display("FAIL empty_addr_c%0d got=rd%0b r%0d c%0d exp=rd%0b r%0d c%0d", tc[i],
                         cap_rd[tc[i]], cap_row[tc[i]], cap_col[tc[i]], trd[i], trow[i], tcol[i]);
            end
        end
`ifdef WIN_SCAN_DIAG_EN
        begin
            int dc [6] = '{98, 101, 102, 103, 168, 169};
            bit drd [6] = '{1, 1, 0, 1, 1, 0};
            int drow [6] = '{2, 5, 0, 1, 2, 0};
            int dcol [6] = '{0, 3, 0, 0, 6, 0};
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (cap_rd[dc[i]] !== drd[i] ||
                    (drd[i] && (cap_row[dc[i]] != 3'(drow[i]) || cap_col[dc[i]] != 3'(dcol[i])))) begin
                    failures++;
                    $display("FAIL diag_addr_c%0d got=rd%0b r%0d c%0d exp=rd%0b r%0d c%0d", dc[i],
                             cap_rd[dc[i]], cap_row[dc[i]], cap_col[dc[i]], drd[i], drow[i], dcol[i]);
                end
            end
        end
`endif
    endtask

    task automatic test_red_row();
        clear_board();
        for (int c = 0; c < 4; c++) board[0][c] = 2'b01;
        run_scan();
        checks++; if (obs_rec_cyc != 6) begin failures++; $display("FAIL red_rec_out_cycle got=%0d exp=6", obs_rec_cyc); end
        checks++; if (obs_done_cyc != 7) begin failures++; $display("FAIL red_done_cycle got=%0d exp=7", obs_done_cyc); end
        checks++; if (obs_winner !== 2'b01) begin failures++; $display("FAIL red_winner got=%b exp=01", obs_winner); end
        checks++; if (cap_rd[7] !== 1'b0) begin failures++; $display("FAIL red_rd_en_c7 got=%0b exp=0", cap_rd[7]); end
        checks++; if (obs_busy_bad != 0) begin failures++; $display("FAIL red_busy_low_cycles got=%0d exp=0", obs_busy_bad); end
        checks++; if (cap_rec_in[1] !== 2'b00) begin failures++; $display("FAIL red_rec_in_c1 got=%b exp=00", cap_rec_in[1]); end
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (cap_rec_in[c] !== 2'b01) begin failures++; $display("FAIL red_rec_in_c%0d got=%b exp=01", c, cap_rec_in[c]); end
        end
        repeat (5) @(negedge clock);
        checks++; if (winner !== 2'b01) begin failures++; $display("FAIL red_winner_held got=%b exp=01", winner); end
    endtask

    task automatic test_yellow_col();
        clear_board();
        for (int r = 2; r < 6; r++) board[r][6] = 2'b10;
        run_scan();
        checks++; if (cap_winner[1] !== 2'b00) begin failures++; $display("FAIL yellow_winner_clear_c1 got=%b exp=00", cap_winner[1]); end
        checks++; if (obs_done_cyc != 99) begin failures++; $display("FAIL yellow_done_cycle got=%0d exp=99", obs_done_cyc); end
        checks++; if (obs_winner !== 2'b10) begin failures++; $display("FAIL yellow_winner got=%b exp=10", obs_winner); end
    endtask

    task automatic test_gap_break();
        clear_board();
        board[0][4] = 2'b01; board[0][5] = 2'b01; board[0][6] = 2'b01; board[1][0] = 2'b01;
        run_scan();
        checks++; if (cap_rec_in[9] !== 2'b00) begin failures++; $display("FAIL gap_rec_in_c9 got=%b exp=00", cap_rec_in[9]); end
        checks++; if (cap_rec_in[10] !== 2'b01) begin failures++; $display("FAIL gap_rec_in_c10 got=%b exp=01", cap_rec_in[10]); end
        checks++; if (obs_done_cyc != LAST_CYC) begin failures++; $display("FAIL gap_done_cycle got=%0d exp=%0d", obs_done_cyc, LAST_CYC); end
        checks++; if (obs_winner !== 2'b00) begin failures++; $display("FAIL gap_winner got=%b exp=00", obs_winner); end
    endtask

    task automatic test_diag();
        clear_board();
        for (int i = 0; i < 4; i++) board[i][i] = 2'b01;
        run_scan();
        checks++; if (obs_done_cyc != DIAG_DONE) begin failures++; $display("FAIL diag_done_cycle got=%0d exp=%0d", obs_done_cyc, DIAG_DONE); end
        checks++; if (obs_winner !== DIAG_WIN) begin failures++; $display("FAIL diag_winner got=%b exp=%b", obs_winner, DIAG_WIN); end
    endtask

    task automatic test_mid_scan_reset();
        clear_board();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (19) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL mid_state_c21 got=%0d exp=1", state_dbg); end
        checks++; if (board_row !== 3'd2 || board_col !== 3'd4) begin failures++; $display("FAIL mid_addr_c21 got=r%0d c%0d exp=r2 c4", board_row, board_col); end
        repeat (19) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (board_rd_en !== 1'b0 || board_row !== 3'd0 || board_col !== 3'd0 || rec_in !== 2'b00 ||
            rec_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || winner !== 2'b00 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=rd%0b r%0d c%0d ri%b rr%0b b%0b d%0b w%b s%0d exp=all zero",
                     board_rd_en, board_row, board_col, rec_in, rec_reset, busy, done, winner, state_dbg);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        run_scan();
        checks++; if (cap_rd[1] !== 1'b1 || cap_row[1] !== 3'd0 || cap_col[1] !== 3'd0) begin failures++; $display("FAIL mid_restart_addr_c1 got=rd%0b r%0d c%0d exp=rd1 r0 c0", cap_rd[1], cap_row[1], cap_col[1]); end
        checks++; if (obs_done_cyc != LAST_CYC) begin failures++; $display("FAIL mid_restart_done got=%0d exp=%0d", obs_done_cyc, LAST_CYC); end
        checks++; if (obs_winner !== 2'b00) begin failures++; $display("FAIL mid_restart_winner got=%b exp=00", obs_winner); end
    endtask

    initial begin
        start = 1'b0;
        reset = 1'b1;
        clear_board();
        test_reset();
        test_empty_board();
        test_red_row();
        test_yellow_col();
        test_gap_break();
        test_diag();
        test_mid_scan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
